// File: rtl/io_hexdisplay.sv
// io_hexdisplay: j1 I/O mapped hex display controller with static per-digit segment
// buses and a time-multiplexed scan output, sharing one decode path.
module io_hexdisplay #(
    parameter int          DIGITS    = 4,
    parameter logic [15:0] BASE_ADDR = 16'h8000,
    parameter int          SCAN_DIV  = 50000,
    parameter int          BLINK_DIV = 12500000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           io_addr,
    input  logic [15:0]           io_wdata,
    input  logic                  io_we,
    input  logic                  io_re,
    output logic [15:0]           io_rdata,
    output logic                  io_rsel,
    output logic [7*DIGITS-1:0]   seg,
    output logic [DIGITS-1:0]     dp,
    output logic [6:0]            seg_mux,
    output logic                  dp_mux,
    output logic [DIGITS-1:0]     dig_sel
);
    localparam int NWORDS  = DIGITS / 4;
    localparam int IDX_W   = $clog2(DIGITS);
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    logic [16*NWORDS-1:0] data_q;
    logic [DIGITS-1:0]    blank_q, dpm_q, blink_q;
    logic                 en_q, frz_q;
    logic [SCAN_W-1:0]    scan_cnt_q;
    logic [IDX_W-1:0]     scan_idx_q;
    logic [BLINK_W-1:0]   blink_cnt_q;
    logic                 phase_q;
    logic [15:0]          rdata_q;
    logic                 rsel_q;
    logic [7*DIGITS-1:0]  seg_q, seg_d;
    logic [DIGITS-1:0]    dp_q, dp_d;
    logic [6:0]           seg_mux_q, seg_mux_d;
    logic                 dp_mux_q, dp_mux_d;
    logic [DIGITS-1:0]    dig_sel_q, dig_sel_d;

    logic [15:0]          off;
    logic                 hit;
    logic [15:0]          rd_val;
    logic [DIGITS-1:0]    vis;

    // Offset arithmetic keeps the decode correct for bases not aligned to 8.
    assign off = io_addr - BASE_ADDR;
    assign hit = (off < 16'd8);

    always_comb begin
        rd_val = '0;
        case (off[2:0])
            3'd4:    rd_val[DIGITS-1:0] = blank_q;
            3'd5:    rd_val[DIGITS-1:0] = dpm_q;
            3'd6:    rd_val[DIGITS-1:0] = blink_q;
            3'd7:    rd_val[1:0] = {frz_q, en_q};
            default: begin
                for (int k = 0; k < NWORDS; k++)
                    if (off[1:0] == 2'(k)) rd_val = data_q[16*k +: 16];
            end
        endcase
    end

    assign vis = {DIGITS{en_q}} & ~blank_q & ~(blink_q & {DIGITS{phase_q}});

    always_comb begin
        seg_d     = '0;
        dp_d      = '0;
        seg_mux_d = 7'h7F;
        dp_mux_d  = 1'b1;
        dig_sel_d = '1;
        for (int i = 0; i < DIGITS; i++) begin
            seg_d[7*i +: 7] = vis[i] ? hex7(data_q[4*i +: 4]) : 7'h7F;
            dp_d[i]         = ~(vis[i] & dpm_q[i]);
            if (scan_idx_q == IDX_W'(i)) begin
                seg_mux_d    = seg_d[7*i +: 7];
                dp_mux_d     = dp_d[i];
                dig_sel_d[i] = ~en_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q      <= {NWORDS{16'h8888}};
            blank_q     <= '0;
            dpm_q       <= '0;
            blink_q     <= '0;
            en_q        <= 1'b1;
            frz_q       <= 1'b0;
            scan_cnt_q  <= '0;
            scan_idx_q  <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            rdata_q     <= '0;
            rsel_q      <= 1'b0;
            seg_q       <= '1;
            dp_q        <= '1;
            seg_mux_q   <= 7'h7F;
            dp_mux_q    <= 1'b1;
            dig_sel_q   <= '1;
        end else begin
            if (io_we && hit) begin
                case (off[2:0])
                    3'd4:    blank_q <= io_wdata[DIGITS-1:0];
                    3'd5:    dpm_q   <= io_wdata[DIGITS-1:0];
                    3'd6:    blink_q <= io_wdata[DIGITS-1:0];
                    3'd7:    begin
                        en_q  <= io_wdata[0];
                        frz_q <= io_wdata[1];
                    end
                    default: begin
                        for (int k = 0; k < NWORDS; k++)
                            if (off[1:0] == 2'(k)) data_q[16*k +: 16] <= io_wdata;
                    end
                endcase
            end
            // rd_val reflects pre-write state, so a same-cycle read sees the old value.
            rsel_q  <= io_re && hit;
            rdata_q <= (io_re && hit) ? rd_val : 16'h0000;

            if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
            end

            if (!frz_q) begin
                if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
                    scan_cnt_q <= '0;
                    scan_idx_q <= (scan_idx_q == IDX_W'(DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
                end else begin
                    scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
                end
            end

            seg_q     <= seg_d;
            dp_q      <= dp_d;
            seg_mux_q <= seg_mux_d;
            dp_mux_q  <= dp_mux_d;
            dig_sel_q <= dig_sel_d;
        end
    end

    assign io_rdata = rdata_q;
    assign io_rsel  = rsel_q;
    assign seg      = seg_q;
    assign dp       = dp_q;
    assign seg_mux  = seg_mux_q;
    assign dp_mux   = dp_mux_q;
    assign dig_sel  = dig_sel_q;
endmodule

// File: tb/tb_io_hexdisplay.sv
// Bench for io_hexdisplay: a 4-digit instance tracked cycle by cycle against a
// behavioural model, plus an 8-digit instance at a different base address.
module tb_io_hexdisplay;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, we_a = 1'b0, re_a = 1'b0;
    logic [15:0] addr_a = 16'h0, wdata_a = 16'h0;
    logic [15:0] rdata_a;
    logic        rsel_a, dpm_a;
    logic [27:0] seg_a;
    logic [3:0]  dp_a, sel_a;
    logic [6:0]  segm_a;

    logic        rst_b = 1'b1, we_b = 1'b0, re_b = 1'b0;
    logic [15:0] addr_b = 16'h0, wdata_b = 16'h0;
    logic [15:0] rdata_b;
    logic        rsel_b, dpm_b;
    logic [55:0] seg_b;
    logic [7:0]  dp_b, sel_b;
    logic [6:0]  segm_b;

    io_hexdisplay #(.DIGITS(4), .BASE_ADDR(16'h8000), .SCAN_DIV(4), .BLINK_DIV(8)) dut_a (
        .clk(clk), .reset(rst_a), .io_addr(addr_a), .io_wdata(wdata_a), .io_we(we_a),
        .io_re(re_a), .io_rdata(rdata_a), .io_rsel(rsel_a), .seg(seg_a), .dp(dp_a),
        .seg_mux(segm_a), .dp_mux(dpm_a), .dig_sel(sel_a));

    io_hexdisplay #(.DIGITS(8), .BASE_ADDR(16'h9000), .SCAN_DIV(4), .BLINK_DIV(8)) dut_b (
        .clk(clk), .reset(rst_b), .io_addr(addr_b), .io_wdata(wdata_b), .io_we(we_b),
        .io_re(re_b), .io_rdata(rdata_b), .io_rsel(rsel_b), .seg(seg_b), .dp(dp_b),
        .seg_mux(segm_b), .dp_mux(dpm_b), .dig_sel(sel_b));

    int checks = 0;
    int errors = 0;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0] pat [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model of the 4-digit instance: register contents plus elapsed
    // tick counts; blink phase and scan index are derived by division.
    logic [15:0] m_data;
    logic [3:0]  m_blank, m_dp, m_blink;
    logic        m_en, m_frz, m_vis, m_hit;
    logic [15:0] m_off;
    int          bticks, sticks, m_ph, m_idx;
    logic [27:0] exp_seg;
    logic [3:0]  exp_dp, exp_sel;
    logic [6:0]  exp_segm;
    logic        exp_dpm, exp_rsel;
    logic [15:0] exp_rdata;

    function automatic logic [15:0] m_read(input logic [2:0] o);
        case (o)
            3'd0:    return m_data;
            3'd4:    return {12'h0, m_blank};
            3'd5:    return {12'h0, m_dp};
            3'd6:    return {12'h0, m_blink};
            3'd7:    return {14'h0, m_frz, m_en};
            default: return 16'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst_a) begin
            m_data = 16'h8888; m_blank = 4'h0; m_dp = 4'h0; m_blink = 4'h0;
            m_en = 1'b1; m_frz = 1'b0; bticks = 0; sticks = 0; m_idx = 0;
            exp_seg = '1; exp_dp = 4'hF; exp_segm = 7'h7F; exp_dpm = 1'b1; exp_sel = 4'hF;
            exp_rsel = 1'b0; exp_rdata = 16'h0;
        end else begin
            m_ph  = (bticks / 8) % 2;
            m_idx = (sticks / 4) % 4;
            for (int i = 0; i < 4; i++) begin
                m_vis = m_en && !m_blank[i] && !(m_blink[i] && m_ph == 1);
                exp_seg[7*i +: 7] = m_vis ? glyph[m_data[4*i +: 4]] : 7'h7F;
                exp_dp[i] = !(m_vis && m_dp[i]);
            end
            exp_segm = exp_seg[7*m_idx +: 7];
            exp_dpm  = exp_dp[m_idx];
            exp_sel  = m_en ? ~(4'b0001 << m_idx) : 4'hF;
            m_off    = addr_a - 16'h8000;
            m_hit    = (m_off < 16'd8);
            exp_rsel  = re_a && m_hit;
            exp_rdata = (re_a && m_hit) ? m_read(m_off[2:0]) : 16'h0;
            bticks++;
            if (!m_frz) sticks++;
            if (we_a && m_hit) begin
                case (m_off[2:0])
                    3'd0: m_data  = wdata_a;
                    3'd4: m_blank = wdata_a[3:0];
                    3'd5: m_dp    = wdata_a[3:0];
                    3'd6: m_blink = wdata_a[3:0];
                    3'd7: begin m_en = wdata_a[0]; m_frz = wdata_a[1]; end
                    default: ;
                endcase
            end
        end
    end

    task automatic check_a(input string tag);
        chk({tag, ".seg"},     64'(seg_a),   64'(exp_seg));
        chk({tag, ".dp"},      64'(dp_a),    64'(exp_dp));
        chk({tag, ".seg_mux"}, 64'(segm_a),  64'(exp_segm));
        chk({tag, ".dp_mux"},  64'(dpm_a),   64'(exp_dpm));
        chk({tag, ".dig_sel"}, 64'(sel_a),   64'(exp_sel));
        chk({tag, ".rsel"},    64'(rsel_a),  64'(exp_rsel));
        chk({tag, ".rdata"},   64'(rdata_a), 64'(exp_rdata));
    endtask

    task automatic step_a(input int n, input string tag);
        repeat (n) begin
            @(negedge clk);
            check_a(tag);
        end
    endtask

    task automatic wr_a(input logic [15:0] a, input logic [15:0] d);
        addr_a = a; wdata_a = d; we_a = 1'b1;
        step_a(1, "wr_a");
        we_a = 1'b0;
    endtask

    task automatic rd_a(input logic [15:0] a);
        addr_a = a; re_a = 1'b1;
        step_a(1, "rd_a");
        re_a = 1'b0;
    endtask

    task automatic wr_b(input logic [15:0] a, input logic [15:0] d);
        addr_b = a; wdata_b = d; we_b = 1'b1;
        @(negedge clk);
        we_b = 1'b0;
    endtask

    task automatic rd_b(input logic [15:0] a, input logic exp_hit, input logic [15:0] exp_d);
        addr_b = a; re_b = 1'b1;
        @(negedge clk);
        re_b = 1'b0;
        chk("b.rsel", 64'(rsel_b), 64'(exp_hit));
        chk("b.rdata", 64'(rdata_b), 64'(exp_d));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int offs, k0;
        logic found;
        logic [3:0] prev, held;
        logic [15:0] a, d, bw [2];

        // Reset, with a read pending that must not produce io_rsel
        addr_a = 16'h8000; re_a = 1'b1;
        repeat (3) @(negedge clk);
        re_a = 1'b0;
        chk("rst.seg", 64'(seg_a), 64'h0FFFFFFF);
        chk("rst.dp", 64'(dp_a), 64'hF);
        chk("rst.seg_mux", 64'(segm_a), 64'h7F);
        chk("rst.dig_sel", 64'(sel_a), 64'hF);
        chk("rst.rsel", 64'(rsel_a), 64'h0);
        chk("rst.rdata", 64'(rdata_a), 64'h0);
        rst_a = 1'b0; rst_b = 1'b0;
        step_a(1, "rel");
        chk("rel.seg8", 64'(seg_a), 64'h0);
        chk("rel.dp", 64'(dp_a), 64'hF);

        wr_a(16'h8000, 16'h1234);
        rd_a(16'h8000);
        chk("data.rdata", 64'(rdata_a), 64'h1234);
        chk("data.rsel", 64'(rsel_a), 64'h1);
        chk("data.digit0", 64'(seg_a[6:0]), 64'h19);
        step_a(1, "idle");
        chk("data.rsel_drop", 64'(rsel_a), 64'h0);

        wr_a(16'h8004, 16'h0002);
        rd_a(16'h8004);
        chk("blank.rdata", 64'(rdata_a), 64'h0002);
        chk("blank.digit1", 64'(seg_a[13:7]), 64'h7F);
        rd_a(16'h8007);
        chk("ctrl.rdata", 64'(rdata_a), 64'h0001);
        rd_a(16'h8001);
        chk("unused.rdata", 64'(rdata_a), 64'h0);
        chk("unused.rsel", 64'(rsel_a), 64'h1);

        wr_a(16'h8006, 16'h0001);
        step_a(1, "blink");
        offs = 0;
        for (int t = 0; t < 32; t++) begin
            step_a(1, "blink");
            if (seg_a[6:0] == 7'h7F) offs++;
            chk("blink.others", 64'(seg_a[27:7]), 64'({7'h79, 7'h24, 7'h7F}));
        end
        chk("blink.off_cycles", 64'(offs), 64'd16);
        wr_a(16'h8006, 16'h0000);
        wr_a(16'h8004, 16'h0000);

        prev = sel_a; found = 1'b0;
        for (int t = 0; t < 8 && !found; t++) begin
            step_a(1, "scan.sync");
            if (sel_a != prev) found = 1'b1;
        end
        chk("scan.sync", 64'(found), 64'h1);
        k0 = m_idx;
        for (int t = 0; t < 16; t++) begin
            chk("scan.seq", 64'(sel_a), 64'(pat[(k0 + t / 4) % 4]));
            step_a(1, "scan");
        end

        wr_a(16'h8007, 16'h0003);
        step_a(1, "freeze");
        held = sel_a;
        for (int t = 0; t < 8; t++) begin
            step_a(1, "freeze");
            chk("freeze.hold", 64'(sel_a), 64'(held));
        end
        wr_a(16'h8007, 16'h0002);
        step_a(1, "disable");
        chk("disable.dig_sel", 64'(sel_a), 64'hF);
        chk("disable.seg", 64'(seg_a), 64'h0FFFFFFF);
        chk("disable.seg_mux", 64'(segm_a), 64'h7F);
        wr_a(16'h8007, 16'h0001);
        wr_a(16'h8005, 16'h000A);

        for (int n = 0; n < 400; n++) begin
            a = ($urandom_range(0, 15) == 0) ? 16'h7FFF : 16'h8000 + 16'($urandom_range(0, 9));
            d = 16'($urandom);
            if (a == 16'h8007 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
            addr_a = a; wdata_a = d;
            we_a = ($urandom_range(0, 2) == 0);
            re_a = ($urandom_range(0, 1) == 0);
            step_a(1, "rand");
        end
        we_a = 1'b0; re_a = 1'b0;
        step_a(2, "rand.tail");

        addr_a = 16'h8000; re_a = 1'b1; rst_a = 1'b1;
        step_a(1, "midrst");
        chk("midrst.rsel", 64'(rsel_a), 64'h0);
        chk("midrst.seg", 64'(seg_a), 64'h0FFFFFFF);
        re_a = 1'b0; rst_a = 1'b0;
        step_a(2, "midrst.rel");

        // 8-digit instance at 16'h9000
        wr_b(16'h9001, 16'hABCD);
        addr_b = 16'h9001; wdata_b = 16'h5555; we_b = 1'b1; re_b = 1'b1;
        @(negedge clk);
        we_b = 1'b0; re_b = 1'b0;
        chk("b.rw_old.rsel", 64'(rsel_b), 64'h1);
        chk("b.rw_old.rdata", 64'(rdata_b), 64'hABCD);
        rd_b(16'h9001, 1'b1, 16'h5555);
        wr_b(16'h9002, 16'h1234);
        rd_b(16'h9002, 1'b1, 16'h0000);
        rd_b(16'h8000, 1'b0, 16'h0000);
        wr_b(16'h9004, 16'hFFFF);
        rd_b(16'h9004, 1'b1, 16'h00FF);
        wr_b(16'h9004, 16'h0000);
        wr_b(16'h9000, 16'hFEDC);
        @(negedge clk);
        chk("b.digit0", 64'(seg_b[6:0]), 64'h46);
        chk("b.digit3", 64'(seg_b[27:21]), 64'h0E);
        chk("b.digit4", 64'(seg_b[34:28]), 64'h12);
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 2; k++) begin
                bw[k] = 16'($urandom);
                wr_b(16'h9000 + 16'(k), bw[k]);
            end
            for (int k = 0; k < 2; k++) rd_b(16'h9000 + 16'(k), 1'b1, bw[k]);
        end

        wr_b(16'h9005, 16'h00FF);
        wr_b(16'h9006, 16'h0055);
        repeat (6) @(negedge clk);
        addr_b = 16'h9000; re_b = 1'b1; rst_b = 1'b1;
        @(negedge clk);
        re_b = 1'b0;
        chk("b.rst.rsel", 64'(rsel_b), 64'h0);
        chk("b.rst.rdata", 64'(rdata_b), 64'h0);
        chk("b.rst.seg", 64'(seg_b), 64'h00FFFFFFFFFFFFFF);
        chk("b.rst.dp", 64'(dp_b), 64'hFF);
        chk("b.rst.seg_mux", 64'(segm_b), 64'h7F);
        chk("b.rst.dp_mux", 64'(dpm_b), 64'h1);
        chk("b.rst.dig_sel", 64'(sel_b), 64'hFF);
        rst_b = 1'b0;
        @(negedge clk);
        chk("b.rel.seg", 64'(seg_b), 64'h0);
        chk("b.rel.dp", 64'(dp_b), 64'hFF);
        chk("b.rel.dig_sel", 64'(sel_b), 64'hFE);
        chk("b.rel.seg_mux", 64'(segm_b), 64'h00);
        rd_b(16'h9000, 1'b1, 16'h8888);
        rd_b(16'h9001, 1'b1, 16'h8888);
        rd_b(16'h9005, 1'b1, 16'h0000);
        rd_b(16'h9006, 1'b1, 16'h0000);
        rd_b(16'h9007, 1'b1, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/io_hexdisplay.md
Name: io_hexdisplay

Overview:
- Parametrised 7-segment display controller on the j1 I/O bus. It replaces the fixed single-word status register at 16'h8000 and the four hard-wired hex decoders in the board top.
- Supports 4..16 hex digits, per-digit blanking, decimal-point and blink masks, and readback.
- Drives both a static (one segment bus per digit) output set and a time-multiplexed (shared segments plus digit select) output set, so one block serves DE0-style and scanned-display boards.

Parameters:
- DIGITS, 4: number of hex digits; a multiple of 4, range 4..16. NWORDS = DIGITS/4.
- BASE_ADDR, 16'h8000: I/O base address. The block decodes BASE_ADDR+0 .. BASE_ADDR+7.
- SCAN_DIV, 50000: clk cycles per digit in multiplexed scan (>=2).
- BLINK_DIV, 12500000: clk cycles per blink phase toggle (>=2).

Ports:
- clk  in  1  clock
- reset  in  1  reset
- io_addr  in  16  j1 I/O address
- io_wdata  in  16  j1 write data
- io_we  in  1  write strobe, one cycle
- io_re  in  1  read strobe, one cycle
- io_rdata  out  16  registered read data
- io_rsel  out  1  high for the cycle in which io_rdata is valid for a hit; top level muxes on this
- seg  out  7*DIGITS  static segments, active-low, digit i at [7i+6:7i], bit order {g,f,e,d,c,b,a}
- dp  out  DIGITS  static decimal points, active-low
- seg_mux  out  7  multiplexed segments, active-low
- dp_mux  out  1  multiplexed decimal point, active-low
- dig_sel  out  DIGITS  multiplexed digit enable, one-hot active-low

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. All state is updated on posedge clk only.
- Register map (offset from BASE_ADDR):
  - 0..3 DATA[k]: nibbles for digits 4k..4k+3; offsets k >= NWORDS are unused.
  - 4 BLANK: bit i forces digit i off.
  - 5 DP: bit i lights the dp of digit i.
  - 6 BLINK: bit i blanks digit i during blink phase 1.
  - 7 CTRL: bit0 ENABLE, bit1 FREEZE (hold the scan index), bits 15:2 read 0.
- Mask bits at or above DIGITS are not stored and read as 0.
- Reset values:
  - DATA = 16'h8888 (all digits show 8); BLANK = DP = BLINK = 0; CTRL = 16'h0001.
  - Scan counter, scan index, blink counter and blink phase = 0.
  - io_rdata = 0, io_rsel = 0.
  - seg = all 1 (off), dp = all 1, seg_mux = 7'h7F, dp_mux = 1, dig_sel = all 1.
  - The first decoded output appears on the cycle after reset deasserts.
- Write: io_we with io_addr in the decoded range updates the register at that edge. Writes to unused DATA offsets or out-of-range addresses are ignored.
- Read:
  - io_re with a hit sets io_rsel=1 and io_rdata=register value on the next edge; both are held for exactly one cycle.
  - Otherwise io_rsel=0 and io_rdata=0.
  - Unused offsets in range still hit and return 0.
- Read and write to the same address in the same cycle: the read returns the pre-write value.
- Digit visibility: visible(i) = ENABLE & ~BLANK[i] & ~(BLINK[i] & phase).
  - seg_i = visible ? hex7(nibble i) : 7'h7F.
  - dp_i = ~(visible & DP[i]).
- hex7 encoding uses standard hex glyphs 0-F (lowercase b and d). For example, 0 gives 7'h40, 8 gives 7'h00, F gives 7'h0E.
- Output latency: static outputs are registered. A write at edge N is visible on seg/dp after edge N+1.
- Blink:
  - The blink counter counts 0..BLINK_DIV-1 and wraps.
  - On wrap, phase toggles.
  - The counter runs regardless of ENABLE.
- Scan:
  - The scan counter counts 0..SCAN_DIV-1.
  - On wrap, the scan index advances, going DIGITS-1 -> 0.
  - FREEZE=1 holds both the counter and the index.
  - dig_sel, seg_mux and dp_mux are registered from the current index: dig_sel has bit idx low, and seg_mux/dp_mux equal seg/dp of digit idx, same cycle alignment.
  - ENABLE=0 drives dig_sel all 1.
- Reset asserted mid-operation (mid-scan, mid-blink, or during a pending read) returns every register and output to its reset value at that edge. No pending io_rsel survives.

Test Plan:
- DIGITS=4, SCAN_DIV=4, BLINK_DIV=8. Assert reset, then release -> one cycle later seg=28'h0000000 (all 8s), dp=4'hF, io_rsel=0.
- Write 16'h1234 to 8000, then read 8000 -> io_rsel=1 for one cycle with io_rdata=16'h1234, and digit0 seg=7'h19 ("4").
- Write BLANK=16'h0002, then read BLANK and 8007 -> seg[13:7]=7'h7F, BLANK reads 16'h0002, 8007 reads 16'h0001. Read 8001 -> 0.
- Write BLINK=16'h0001 and observe 32 cycles -> digit0 alternates between its glyph and 7'h7F every 8 cycles; other digits are steady.
- Observe scan for 16 cycles -> dig_sel follows E,D,B,7, each held 4 cycles. Set FREEZE -> index holds. Clear ENABLE -> dig_sel=F and seg all 7'h7F.
- DIGITS=8, BASE_ADDR=16'h9000:
  - Same-cycle read and write of 9001 -> read returns the old value.
  - Write to 9002 -> ignored.
  - Reset mid-scan -> all registers and outputs return to their reset values.
